// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes and
// the mux-select codes that the immediate generator and datapath muxes decode.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_UPPER  = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_R   = 2'd1;
  localparam logic [1:0] ALU_I   = 2'd2;

  localparam logic [1:0] A_PC     = 2'd0;
  localparam logic [1:0] A_OLD_PC = 2'd1;
  localparam logic [1:0] A_RS1    = 2'd2;
  localparam logic [1:0] A_ZERO   = 2'd3;

  localparam logic [1:0] B_RS2 = 2'd0;
  localparam logic [1:0] B_IMM = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MDR = 2'd1;
  localparam logic [1:0] WB_SEL_RA  = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // DECODE dispatch; unknown opcodes land in TRAP.
  function automatic state_t dispatch(input logic [6:0] opc);
    state_t s;
    case (opc)
      OPC_R:                s = S_EXEC_R;
      OPC_I:                s = S_EXEC_I;
      OPC_LOAD, OPC_STORE:  s = S_ADDR;
      OPC_BRANCH:           s = S_BRANCH;
      OPC_JAL:              s = S_JAL;
      OPC_JALR:             s = S_JALR;
      OPC_LUI, OPC_AUIPC:   s = S_UPPER;
      default:              s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Purely combinational Moore output map: state (plus opcode for ADDR/UPPER)
// to datapath strobes and selects. i_mem_ok gates the wait-sensitive strobes.
module mc_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [6:0] i_opcode,
  input  logic       i_branch_taken,
  input  logic       i_mem_ok,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl           = '0;
    o_ctrl.imm_sel   = IMM_I;
    o_ctrl.alu_src_a = A_PC;
    o_ctrl.alu_src_b = B_RS2;
    o_ctrl.alu_op    = ALU_ADD;
    o_ctrl.pc_src    = PC_SEQ;
    o_ctrl.wb_sel    = WB_SEL_ALU;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read     = 1'b1;
        o_ctrl.mem_addr_sel = 1'b0;
        o_ctrl.ir_write     = i_mem_ok;
        o_ctrl.pc_write     = i_mem_ok;
      end
      // Speculative branch target into ALUOut while the opcode is dispatched.
      S_DECODE: begin
        o_ctrl.alu_src_a = A_OLD_PC;
        o_ctrl.alu_src_b = B_IMM;
        o_ctrl.imm_sel   = IMM_B;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = A_RS1;
        o_ctrl.alu_src_b = B_RS2;
        o_ctrl.alu_op    = ALU_R;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = A_RS1;
        o_ctrl.alu_src_b = B_IMM;
        o_ctrl.alu_op    = ALU_I;
      end
      S_ADDR: begin
        o_ctrl.alu_src_a = A_RS1;
        o_ctrl.alu_src_b = B_IMM;
        o_ctrl.imm_sel   = (i_opcode == OPC_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read     = 1'b1;
        o_ctrl.mem_addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write    = 1'b1;
        o_ctrl.mem_addr_sel = 1'b1;
        o_ctrl.instr_done   = i_mem_ok;
      end
      S_WB_ALU: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_WB_MEM: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.wb_sel     = WB_SEL_MDR;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.pc_write   = i_branch_taken;
        o_ctrl.pc_src     = PC_TARGET;
        o_ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        o_ctrl.alu_src_a  = A_OLD_PC;
        o_ctrl.alu_src_b  = B_IMM;
        o_ctrl.imm_sel    = IMM_J;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.wb_sel     = WB_SEL_RA;
        o_ctrl.instr_done = 1'b1;
      end
      S_JALR: begin
        o_ctrl.alu_src_a  = A_RS1;
        o_ctrl.alu_src_b  = B_IMM;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_src     = PC_JALR;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.wb_sel     = WB_SEL_RA;
        o_ctrl.instr_done = 1'b1;
      end
      // LUI adds the immediate to zero, AUIPC to old_pc.
      S_UPPER: begin
        o_ctrl.alu_src_a  = (i_opcode == OPC_LUI) ? A_ZERO : A_OLD_PC;
        o_ctrl.alu_src_b  = B_IMM;
        o_ctrl.imm_sel    = IMM_U;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_TRAP: begin
        o_ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: state register and next-state logic; outputs
// come from mc_output_decode. Define MEM_WAIT_EN to stall memory states on mem_ready.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic [1:0]         pc_src,
  output logic [2:0]         imm_sel,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_addr_sel,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_dec;
  ctrl_t  w_ctrl;
  logic   w_mem_ok;

`ifdef MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  w_next_state = w_mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: w_next_state = dispatch(opcode);
      S_EXEC_R: w_next_state = S_WB_ALU;
      S_EXEC_I: w_next_state = S_WB_ALU;
      S_ADDR:   w_next_state = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: w_next_state = w_mem_ok ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: w_next_state = w_mem_ok ? S_FETCH : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_BRANCH,
      S_JAL, S_JALR, S_UPPER:
                w_next_state = S_FETCH;
      S_TRAP:   w_next_state = S_TRAP;
      default:  w_next_state = S_FETCH;
    endcase
  end

  mc_output_decode u_dec (
    .i_state        (r_state),
    .i_opcode       (opcode),
    .i_branch_taken (branch_taken),
    .i_mem_ok       (w_mem_ok),
    .o_ctrl         (w_dec)
  );

  // Reset suppresses every side effect of the aborted instruction.
  always_comb begin
    w_ctrl = w_dec;
    if (reset) begin
      w_ctrl.pc_write   = 1'b0;
      w_ctrl.ir_write   = 1'b0;
      w_ctrl.mem_read   = 1'b0;
      w_ctrl.mem_write  = 1'b0;
      w_ctrl.reg_write  = 1'b0;
      w_ctrl.instr_done = 1'b0;
      w_ctrl.illegal    = 1'b0;
    end
  end

  assign pc_write     = w_ctrl.pc_write;
  assign ir_write     = w_ctrl.ir_write;
  assign pc_src       = w_ctrl.pc_src;
  assign imm_sel      = w_ctrl.imm_sel;
  assign alu_src_a    = w_ctrl.alu_src_a;
  assign alu_src_b    = w_ctrl.alu_src_b;
  assign alu_op       = w_ctrl.alu_op;
  assign mem_read     = w_ctrl.mem_read;
  assign mem_write    = w_ctrl.mem_write;
  assign mem_addr_sel = w_ctrl.mem_addr_sel;
  assign reg_write    = w_ctrl.reg_write;
  assign wb_sel       = w_ctrl.wb_sel;
  assign instr_done   = w_ctrl.instr_done;
  assign illegal      = w_ctrl.illegal;
  assign state_dbg    = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle vector table for each
// instruction class plus hand sequences for trap, reset abort and wait states.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, mem_addr_sel;
  logic       reg_write, instr_done, illegal;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] imm_sel;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .pc_src(pc_src), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .reg_write(reg_write),
    .wb_sel(wb_sel), .instr_done(instr_done), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  typedef logic [24:0] vec_t;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic       bt;
    vec_t       exp;
  } row_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb_q[$];
  row_t tbl[$];

  // {state, pcw, irw, pc_src, imm, a, b, op, mrd, mwr, maddr, rw, wb, done, ill}
  function automatic vec_t e(input int st, input int pcw, input int irw, input int pcs,
                             input int imm, input int a, input int b, input int op,
                             input int mr, input int mw, input int mas, input int rw,
                             input int wb, input int dn, input int il);
    return {4'(st), 1'(pcw), 1'(irw), 2'(pcs), 3'(imm), 2'(a), 2'(b), 2'(op),
            1'(mr), 1'(mw), 1'(mas), 1'(rw), 2'(wb), 1'(dn), 1'(il)};
  endfunction

  function automatic vec_t actual();
    return {state_dbg, pc_write, ir_write, pc_src, imm_sel, alu_src_a, alu_src_b,
            alu_op, mem_read, mem_write, mem_addr_sel, reg_write, wb_sel,
            instr_done, illegal};
  endfunction

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011,
                         O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                         O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111,
                         O_BAD = 7'h7F;

  vec_t v_fetch, v_decode, v_trap, v_zero;

  task automatic check_now(input string name);
    vec_t exp, act;
    exp = sb_q.pop_front();
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %07h expected %07h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic [6:0] opc,
                      input logic bt, input logic mr, input vec_t exp);
    @(negedge clk);
    reset        = rst;
    opcode       = opc;
    branch_taken = bt;
    mem_ready    = mr;
    sb_q.push_back(exp);
    #1;
    check_now(name);
  endtask

  task automatic add_row(input string name, input logic [6:0] opc, input logic bt,
                         input vec_t exp);
    row_t r;
    r.name = name; r.opc = opc; r.bt = bt; r.exp = exp;
    tbl.push_back(r);
  endtask

  initial begin
    v_fetch  = e(0, 1,1,0, 0, 0,0,0, 1,0,0, 0,0,0,0);
    v_decode = e(1, 0,0,0, 2, 1,2,0, 0,0,0, 0,0,0,0);
    v_trap   = e(13,0,0,0, 0, 0,0,0, 0,0,0, 0,0,0,1);
    v_zero   = '0;

    // ADD x3,x1,x2
    add_row("add_fetch",  O_R, 0, v_fetch);
    add_row("add_decode", O_R, 0, v_decode);
    add_row("add_exec",   O_R, 0, e(2, 0,0,0, 0, 2,0,1, 0,0,0, 0,0,0,0));
    add_row("add_wb",     O_R, 0, e(7, 0,0,0, 0, 0,0,0, 0,0,0, 1,0,1,0));
    // LW x5,8(x1)
    add_row("lw_fetch",   O_LD, 0, v_fetch);
    add_row("lw_decode",  O_LD, 0, v_decode);
    add_row("lw_addr",    O_LD, 0, e(4, 0,0,0, 0, 2,2,0, 0,0,0, 0,0,0,0));
    add_row("lw_memrd",   O_LD, 0, e(5, 0,0,0, 0, 0,0,0, 1,0,1, 0,0,0,0));
    add_row("lw_wb",      O_LD, 0, e(8, 0,0,0, 0, 0,0,0, 0,0,0, 1,1,1,0));
    // BEQ taken, then not taken
    add_row("beqt_fetch", O_BR, 1, v_fetch);
    add_row("beqt_dec",   O_BR, 1, v_decode);
    add_row("beqt_br",    O_BR, 1, e(9, 1,0,1, 0, 0,0,0, 0,0,0, 0,0,1,0));
    add_row("beqn_fetch", O_BR, 0, v_fetch);
    add_row("beqn_dec",   O_BR, 0, v_decode);
    add_row("beqn_br",    O_BR, 0, e(9, 0,0,1, 0, 0,0,0, 0,0,0, 0,0,1,0));
    // ADDI
    add_row("addi_fetch", O_I, 0, v_fetch);
    add_row("addi_dec",   O_I, 0, v_decode);
    add_row("addi_exec",  O_I, 0, e(3, 0,0,0, 0, 2,2,2, 0,0,0, 0,0,0,0));
    add_row("addi_wb",    O_I, 0, e(7, 0,0,0, 0, 0,0,0, 0,0,0, 1,0,1,0));
    // SW
    add_row("sw_fetch",   O_ST, 0, v_fetch);
    add_row("sw_dec",     O_ST, 0, v_decode);
    add_row("sw_addr",    O_ST, 0, e(4, 0,0,0, 1, 2,2,0, 0,0,0, 0,0,0,0));
    add_row("sw_memwr",   O_ST, 0, e(6, 0,0,0, 0, 0,0,0, 0,1,1, 0,0,1,0));
    // JAL, JALR, LUI, AUIPC
    add_row("jal_fetch",  O_JAL, 0, v_fetch);
    add_row("jal_dec",    O_JAL, 0, v_decode);
    add_row("jal_ex",     O_JAL, 0, e(10,1,0,0, 4, 1,2,0, 0,0,0, 1,2,1,0));
    add_row("jalr_fetch", O_JALR, 0, v_fetch);
    add_row("jalr_dec",   O_JALR, 0, v_decode);
    add_row("jalr_ex",    O_JALR, 0, e(11,1,0,2, 0, 2,2,0, 0,0,0, 1,2,1,0));
    add_row("lui_fetch",  O_LUI, 0, v_fetch);
    add_row("lui_dec",    O_LUI, 0, v_decode);
    add_row("lui_ex",     O_LUI, 0, e(12,0,0,0, 3, 3,2,0, 0,0,0, 1,0,1,0));
    add_row("auipc_fetch",O_AUIPC, 0, v_fetch);
    add_row("auipc_dec",  O_AUIPC, 0, v_decode);
    add_row("auipc_ex",   O_AUIPC, 0, e(12,0,0,0, 3, 1,2,0, 0,0,0, 1,0,1,0));

    reset = 1'b1; opcode = O_R; branch_taken = 1'b0; mem_ready = 1'b1;
    step("reset_hold", 1, O_R, 0, 1, v_zero);

    foreach (tbl[i]) step(tbl[i].name, 0, tbl[i].opc, tbl[i].bt, 1, tbl[i].exp);

    // Illegal opcode parks in TRAP until reset
    step("trap_fetch", 0, O_BAD, 0, 1, v_fetch);
    step("trap_dec",   0, O_BAD, 0, 1, v_decode);
    for (int k = 0; k < 10; k++) step($sformatf("trap_hold%0d", k), 0, O_BAD, 0, 1, v_trap);
    step("trap_rst_in",  1, O_BAD, 0, 1, e(13,0,0,0, 0, 0,0,0, 0,0,0, 0,0,0,0));
    step("trap_rst_out", 1, O_R,   0, 1, v_zero);
    step("trap_refetch", 0, O_R,   0, 1, v_fetch);
    step("trap_redec",   0, O_R,   0, 1, v_decode);
    step("trap_reexec",  0, O_R,   0, 1, e(2, 0,0,0, 0, 2,0,1, 0,0,0, 0,0,0,0));
    step("trap_rewb",    0, O_R,   0, 1, e(7, 0,0,0, 0, 0,0,0, 0,0,0, 1,0,1,0));

    // Reset during MEM_WR of SW aborts the store
    step("swr_fetch", 0, O_ST, 0, 1, v_fetch);
    step("swr_dec",   0, O_ST, 0, 1, v_decode);
    step("swr_addr",  0, O_ST, 0, 1, e(4, 0,0,0, 1, 2,2,0, 0,0,0, 0,0,0,0));
    step("swr_memwr", 0, O_ST, 0, 1, e(6, 0,0,0, 0, 0,0,0, 0,1,1, 0,0,1,0));
    reset = 1'b1;
    sb_q.push_back(e(6, 0,0,0, 0, 0,0,0, 0,0,1, 0,0,0,0));
    #1;
    check_now("swr_rst_memwr");
    step("swr_after_rst", 0, O_ST, 0, 1, v_fetch);

`ifdef MEM_WAIT_EN
    // FETCH stalls on mem_ready with mem_read held and pc/ir writes gated
    step("wait_dec", 0, O_LD, 0, 1, v_decode);
    step("wait_addr", 0, O_LD, 0, 1, e(4, 0,0,0, 0, 2,2,0, 0,0,0, 0,0,0,0));
    step("wait_rd0", 0, O_LD, 0, 0, e(5, 0,0,0, 0, 0,0,0, 1,0,1, 0,0,0,0));
    step("wait_rd1", 0, O_LD, 0, 1, e(5, 0,0,0, 0, 0,0,0, 1,0,1, 0,0,0,0));
    step("wait_wb",  0, O_LD, 0, 1, e(8, 0,0,0, 0, 0,0,0, 0,0,0, 1,1,1,0));
    for (int k = 0; k < 3; k++)
      step($sformatf("wait_fetch%0d", k), 0, O_ST, 0, 0, e(0, 0,0,0, 0, 0,0,0, 1,0,0, 0,0,0,0));
    step("wait_fetch_rdy", 0, O_ST, 0, 1, v_fetch);
    step("wait_st_dec",    0, O_ST, 0, 1, v_decode);
    step("wait_st_addr",   0, O_ST, 0, 1, e(4, 0,0,0, 1, 2,2,0, 0,0,0, 0,0,0,0));
    step("wait_wr0",       0, O_ST, 0, 0, e(6, 0,0,0, 0, 0,0,0, 0,1,1, 0,0,0,0));
    step("wait_wr1",       0, O_ST, 0, 1, e(6, 0,0,0, 0, 0,0,0, 0,1,1, 0,0,1,0));
    step("wait_next",      0, O_R,  0, 1, v_fetch);
`else
    // mem_ready is ignored: a low mem_ready never stalls
    step("nowait_dec",   0, O_ST, 0, 0, v_decode);
    step("nowait_addr",  0, O_ST, 0, 0, e(4, 0,0,0, 1, 2,2,0, 0,0,0, 0,0,0,0));
    step("nowait_memwr", 0, O_ST, 0, 0, e(6, 0,0,0, 0, 0,0,0, 0,1,1, 0,0,1,0));
    step("nowait_fetch", 0, O_I,  0, 0, v_fetch);
    step("nowait_idec",  0, O_I,  0, 0, v_decode);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
